scan_ctrl_sync: RTL and testbench

Parametrised, clk-synchronous successor to the two-phase scan chain. It oversamples the external scan pins on the core clock and shifts a configurable-length chain of config bits plus observe bits. Config updates are committed only when exactly one full chain length has been shifted, which guards the CNN weights, bias and mode controls against truncated or over-long scan loads. It sits between the chip scan pads and the CNN, clock-generator and test-mux config buses.

---
 rtl/scan_ctrl_sync.sv | 99 +++++++++
 tb/tb_scan_ctrl_sync.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl_sync.sv
// Clock-synchronous scan chain controller: oversamples scan pins on clk,
// shifts config+observe bits, commits config only on exact-length loads.
module scan_ctrl_sync #(
  parameter int CFG_W = 128,
  parameter int OBS_W = 64,
  parameter int SYNC_STAGES = 2,
  parameter logic [CFG_W-1:0] CFG_RESET = '0,
  localparam int L = CFG_W + OBS_W,
  localparam int CW = $clog2(L + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_clk,
  input  logic             scan_in,
  input  logic             scan_en,
  input  logic             scan_capture,
  input  logic             scan_load,
  output logic             scan_out,
  input  logic [OBS_W-1:0] obs_i,
  output logic [CFG_W-1:0] cfg_o,
  output logic             cfg_valid,
  output logic             upd_ok,
  output logic             upd_err,
  output logic [CW-1:0]    shift_cnt
);

  localparam logic [CW-1:0] CNT_FULL = CW'(L);
  localparam logic [CW-1:0] CNT_SAT  = CW'(L + 1);

  logic [SYNC_STAGES-1:0][4:0] sync_q;
  logic [4:0] pins_s;
  logic       sclk_s;
  logic       in_s;
  logic       en_s;
  logic       cap_s;
  logic       ld_s;
  logic       sclk_q;
  logic       fire;
  logic [L-1:0] chain;

  // All five pins share one chain so they stay mutually aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0],
                 {scan_load, scan_capture, scan_en, scan_in, scan_clk}};
    end
  end

  assign pins_s = sync_q[SYNC_STAGES-1];
  assign sclk_s = pins_s[0];
  assign in_s   = pins_s[1];
  assign en_s   = pins_s[2];
  assign cap_s  = pins_s[3];
  assign ld_s   = pins_s[4];
  assign fire   = sclk_s & ~sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      chain     <= '0;
      scan_out  <= 1'b0;
      cfg_o     <= CFG_RESET;
      cfg_valid <= 1'b0;
      upd_ok    <= 1'b0;
      upd_err   <= 1'b0;
      shift_cnt <= '0;
    end else begin
      sclk_q <= sclk_s;
      upd_ok <= 1'b0;
      if (fire) begin
        if (ld_s) begin
          shift_cnt <= '0;
          if (shift_cnt == CNT_FULL) begin
            cfg_o     <= chain[L-1:OBS_W];
            cfg_valid <= 1'b1;
            upd_err   <= 1'b0;
            upd_ok    <= 1'b1;
          end else begin
            upd_err <= 1'b1;
          end
        end else if (cap_s) begin
          chain     <= {cfg_o, obs_i};
          scan_out  <= obs_i[0];
          shift_cnt <= '0;
        end else if (en_s) begin
          chain    <= {in_s, chain[L-1:1]};
          scan_out <= chain[1];
          // Saturate so an over-long load can never alias back to L.
          if (shift_cnt != CNT_SAT) begin
            shift_cnt <= shift_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_ctrl_sync.sv
// Scoreboard bench for scan_ctrl_sync: queue-based reference model of the
// scan chain, expected snapshots checked by an independent monitor.
module tb_scan_ctrl_sync;

  localparam int CFG_W = 8;
  localparam int OBS_W = 4;
  localparam int L = 12;
  localparam logic [7:0] CFG_RST = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scan_clk = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_en = 1'b0;
  logic       scan_capture = 1'b0;
  logic       scan_load = 1'b0;
  logic [3:0] obs_i = 4'h0;
  logic       scan_out;
  logic [7:0] cfg_o;
  logic       cfg_valid;
  logic       upd_ok;
  logic       upd_err;
  logic [3:0] shift_cnt;

  scan_ctrl_sync #(
    .CFG_W(CFG_W),
    .OBS_W(OBS_W),
    .SYNC_STAGES(2),
    .CFG_RESET(CFG_RST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scan_clk(scan_clk),
    .scan_in(scan_in),
    .scan_en(scan_en),
    .scan_capture(scan_capture),
    .scan_load(scan_load),
    .scan_out(scan_out),
    .obs_i(obs_i),
    .cfg_o(cfg_o),
    .cfg_valid(cfg_valid),
    .upd_ok(upd_ok),
    .upd_err(upd_err),
    .shift_cnt(shift_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] cfg;
    logic       valid;
    logic       err;
    logic       so;
    int         cnt;
    int         ok;
  } exp_t;

  exp_t exp_q[$];

  bit         m_q[$];
  logic [7:0] m_cfg;
  bit         m_valid;
  bit         m_err;
  int         m_cnt;
  int         m_ok = 0;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  ok_seen = 0;
  int  drain = 0;
  bit  done = 1'b0;

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < L; i++) m_q.push_back(1'b0);
    m_cfg = CFG_RST;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic model_act(bit en, bit din, bit cap, bit ld,
                           logic [3:0] obs);
    if (ld) begin
      if (m_cnt == L) begin
        for (int i = 0; i < CFG_W; i++) m_cfg[i] = m_q[OBS_W + i];
        m_valid = 1'b1;
        m_err = 1'b0;
        m_ok++;
      end else begin
        m_err = 1'b1;
      end
      m_cnt = 0;
    end else if (cap) begin
      m_q.delete();
      for (int i = 0; i < OBS_W; i++) m_q.push_back(obs[i]);
      for (int i = 0; i < CFG_W; i++) m_q.push_back(m_cfg[i]);
      m_cnt = 0;
    end else if (en) begin
      void'(m_q.pop_front());
      m_q.push_back(din);
      if (m_cnt < L + 1) m_cnt++;
    end
  endtask

  task automatic push(string tag);
    exp_t e;
    e.tag = tag;
    e.cfg = m_cfg;
    e.valid = m_valid;
    e.err = m_err;
    e.so = m_q[0];
    e.cnt = m_cnt;
    e.ok = m_ok;
    exp_q.push_back(e);
  endtask

  task automatic pulse(bit en, bit din, bit cap, bit ld, int hi,
                       string tag);
    @(negedge clk);
    scan_en = en;
    scan_in = din;
    scan_capture = cap;
    scan_load = ld;
    repeat (4) @(negedge clk);
    scan_clk = 1'b1;
    repeat (hi) @(negedge clk);
    model_act(en, din, cap, ld, obs_i);
    push(tag);
    scan_clk = 1'b0;
    scan_en = 1'b0;
    scan_capture = 1'b0;
    scan_load = 1'b0;
    scan_in = 1'($urandom);
  endtask

  task automatic shift_bits(logic [31:0] v, int n, string tag);
    for (int i = 0; i < n; i++) pulse(1'b1, v[i], 1'b0, 1'b0, 4, tag);
  endtask

  task automatic do_reset(string tag);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    push(tag);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    push(tag);
  endtask

  function automatic void chk(string tag, string fld,
                              logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
    end
  endfunction

  function automatic void summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (upd_ok === 1'b1) ok_seen++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "cfg_o", 32'(cfg_o), 32'(e.cfg));
      chk(e.tag, "cfg_valid", 32'(cfg_valid), 32'(e.valid));
      chk(e.tag, "upd_err", 32'(upd_err), 32'(e.err));
      chk(e.tag, "scan_out", 32'(scan_out), 32'(e.so));
      chk(e.tag, "shift_cnt", 32'(shift_cnt), 32'(e.cnt));
      chk(e.tag, "upd_ok_pulses", 32'(ok_seen), 32'(e.ok));
    end else if (done) begin
      summary();
      $finish;
    end
    if (done) begin
      drain++;
      if (drain > 100) begin
        n_cmp++;
        n_bad++;
        $display("FAIL drain: %0d left, expected 0", exp_q.size());
        summary();
        $finish;
      end
    end
  end

  initial begin
    int op;
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    push("reset_idle");

    shift_bits(32'hA50, 12, "load_a5");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4, "upd_a5");

    shift_bits($urandom, 11, "short");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4, "upd_short");
    shift_bits($urandom, 12, "full");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4, "upd_full");

    shift_bits($urandom, 20, "sat");
    pulse(1'b0, 1'b0, 1'b0, 1'b1, 4, "upd_long");

    obs_i = 4'hC;
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 4, "capture");
    shift_bits($urandom, 12, "readback");

    shift_bits($urandom, 12, "pre_both");
    pulse(1'b1, 1'b1, 1'b1, 1'b1, 4, "load_cap");
    shift_bits($urandom, 5, "partial");
    do_reset("mid_reset");

    pulse(1'b0, 1'b1, 1'b0, 1'b0, 4, "idle_act");
    pulse(1'b1, 1'b1, 1'b0, 1'b0, 20, "long_high");

    for (int k = 0; k < 60; k++) begin
      op = int'($urandom_range(0, 9));
      obs_i = 4'($urandom);
      if (op <= 5) begin
        pulse(1'b1, 1'($urandom), 1'b0, 1'b0, 4, "rnd_shift");
      end else if (op == 6) begin
        pulse(1'($urandom), 1'($urandom), 1'b1, 1'b0, 4, "rnd_cap");
      end else if (op == 7) begin
        pulse(1'($urandom), 1'($urandom), 1'($urandom), 1'b1, 4,
              "rnd_load");
      end else if (op == 8) begin
        pulse(1'b0, 1'($urandom), 1'b0, 1'b0, 4, "rnd_idle");
      end else begin
        n = int'($urandom_range(10, 14));
        shift_bits($urandom, n, "rnd_burst");
        pulse(1'b0, 1'b0, 1'b0, 1'b1, 4, "rnd_burst_upd");
      end
    end

    repeat (5) @(negedge clk);
    done = 1'b1;
  end

endmodule
